// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: arbitration states and master indices.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef logic mst_idx_t;

  localparam mst_idx_t M0 = 1'b0;
  localparam mst_idx_t M1 = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-master pick: a valid lock owner wins, otherwise round-robin.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  mst_idx_t   last_grant,
  input  mst_idx_t   owner,
  input  logic       owner_valid,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (owner_valid && (owner == M0) && req0) begin
      gnt = 2'b01;
    end else if (owner_valid && (owner == M1) && req1) begin
      gnt = 2'b10;
    end else if (req0 && req1) begin
      gnt = (last_grant == M0) ? 2'b10 : 2'b01;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter with bounded lock ownership and a 1-cycle load return path.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [DM_ADDRESS-1:0] m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [2:0]            m0_funct3,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [DM_ADDRESS-1:0] m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [2:0]            m1_funct3,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  arb_state_e        state_q, state_d;
  mst_idx_t          last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic [1:0] pick;
  logic [1:0] gnt;
  mst_idx_t   owner;
  mst_idx_t   gnt_idx;
  logic       owner_valid;
  logic       sel_lock;

  assign owner       = (state_q == OWN1) ? M1 : M0;
  assign owner_valid = (state_q != IDLE) && (lock_cnt_q < LOCK_MAX);

  dmem_rr_pick u_pick (
    .req0        (m0_req),
    .req1        (m1_req),
    .last_grant  (last_grant_q),
    .owner       (owner),
    .owner_valid (owner_valid),
    .gnt         (pick)
  );

  assign gnt     = rst_n ? pick : '0;
  assign gnt_idx = gnt[1] ? M1 : M0;
  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];

  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    a        = '0;
    wd       = '0;
    Funct3   = '0;
    sel_lock = 1'b0;
    if (gnt[0]) begin
      MemWrite = m0_we;
      MemRead  = ~m0_we;
      a        = m0_addr;
      wd       = m0_wdata;
      Funct3   = m0_funct3;
      sel_lock = m0_lock;
    end else if (gnt[1]) begin
      MemWrite = m1_we;
      MemRead  = ~m1_we;
      a        = m1_addr;
      wd       = m1_wdata;
      Funct3   = m1_funct3;
      sel_lock = m1_lock;
    end
  end

  // Re-granting the same owner after its lock window expired starts a fresh window at 1.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    if (|gnt) begin
      last_grant_d = gnt_idx;
      if (sel_lock) begin
        state_d = (gnt_idx == M1) ? OWN1 : OWN0;
        if ((state_q == state_d) && (lock_cnt_q < LOCK_MAX)) begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end else begin
          lock_cnt_d = CNT_W'(1);
        end
      end else begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    end else if (state_q != IDLE) begin
      state_d    = IDLE;
      lock_cnt_d = '0;
    end
  end

  always_comb begin
    rvalid_d   = '0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    if (MemRead) begin
      rvalid_d = gnt;
      if (gnt[0]) m0_rdata_d = rd;
      if (gnt[1]) m1_rdata_d = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= M1;
      lock_cnt_q   <= '0;
      rvalid_q     <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      rvalid_q     <= rvalid_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // Gating by rst_n hides a pulse registered on the edge just before reset asserts.
  assign m0_rvalid = rvalid_q[0] & rst_n;
  assign m1_rvalid = rvalid_q[1] & rst_n;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have parameters: DM_ADDRESS, default 9, data-memory word/byte address width; DATA_W, default 32, data width; MAX_LOCK, default 8, maximum consecutive locked grants.
REQ-002 The module SHALL have ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- m0_req/m1_req  in  1  access request, core LSU (m0) and loader/debug port (m1).
- m0_we/m1_we  in  1  1=store, 0=load.
- m0_lock/m1_lock  in  1  keep ownership for the next access.
- m0_addr/m1_addr  in  DM_ADDRESS  byte address.
- m0_wdata/m1_wdata  in  DATA_W  store data.
- m0_funct3/m1_funct3  in  3  access size/sign code, passed through.
- m0_gnt/m1_gnt  out  1  access accepted this cycle.
- m0_rvalid/m1_rvalid  out  1  load data valid.
- m0_rdata/m1_rdata  out  DATA_W  load data.
- MemRead/MemWrite  out  1  data-memory controls.
- a  out  DM_ADDRESS  data-memory address.
- wd  out  DATA_W  data-memory write data.
- Funct3  out  3  data-memory access code.
- rd  in  DATA_W  data-memory read data, valid in the issue cycle.

Function
REQ-003 At most one of m0_gnt, m1_gnt SHALL be high in any cycle; the granted master's we/addr/wdata/funct3 SHALL drive MemWrite=we, MemRead=~we, a, wd, Funct3 combinationally in that cycle.
REQ-004 With no grant, MemRead, MemWrite, a, wd and Funct3 SHALL be 0.
REQ-005 A requester SHALL hold req and its request fields stable until it sees gnt; gnt SHALL be a single-cycle acceptance, with a new access needing req high again in a later cycle.
REQ-006 States SHALL be IDLE, OWN0, OWN1; OWNn means master n holds a lock.
REQ-007 In IDLE with one requester, that requester SHALL be granted; with both, the master not named by the last_grant register SHALL be granted (round-robin).
REQ-008 last_grant SHALL update to the granted master index on every grant.
REQ-009 A grant with the requester's lock=1 SHALL move to OWNn and increment lock_cnt; a grant with lock=0 SHALL move to IDLE and clear lock_cnt.
REQ-010 In OWNn, master n SHALL win over the other master whenever mn_req=1 and lock_cnt < MAX_LOCK.
REQ-011 In OWNn with mn_req=0, arbitration SHALL proceed as in IDLE: the other master may win, the state leaves OWNn, and lock_cnt clears.
REQ-012 When lock_cnt reaches MAX_LOCK, the lock SHALL be ignored for one arbitration; a waiting other master SHALL then win, with the state and lock_cnt updated per REQ-009.
REQ-013 For a granted load, rd SHALL be registered and returned on the granted master's rdata with rvalid high exactly one cycle after gnt (latency 1); stores SHALL produce no rvalid.
REQ-014 rvalid SHALL be a one-cycle pulse; rdata SHALL hold its last value when rvalid=0.
REQ-015 Back-to-back loads (grant every cycle) SHALL be supported at full throughput, with each rvalid attributed to the master granted in the prior cycle.
REQ-016 The block SHALL not modify addr, wdata or funct3; alignment and byte-lane handling remain in the data memory.

Reset
REQ-017 While rst_n=0 at a rising edge, the block SHALL set: state=IDLE, last_grant=1 (m0 wins the first conflict), lock_cnt=0, m0/m1_rvalid=0, m0/m1_rdata=0.
REQ-018 While rst_n=0, no gnt SHALL be issued, and MemRead/MemWrite SHALL be 0.
REQ-019 Reset asserted the cycle after a load grant SHALL suppress that rvalid.

Structure
REQ-020 A package dmem_arb_pkg SHALL hold the state enum (IDLE, OWN0, OWN1), a 1-bit master index type, and the M0/M1 index constants.
REQ-021 A combinational sub-module dmem_rr_pick (inputs: req0, req1, last_grant, owner, owner_valid; outputs: grant vector) SHALL implement the selection, with state, counter and the return path held in dmem_arbiter.

Verification
REQ-022 Reset, then m0 and m1 both load in the same cycle: m0_gnt=1 cycle 0; m1_gnt=1 cycle 1; m0_rvalid cycle 1; m1_rvalid cycle 2.
REQ-023 m1 stores wdata=32'hDEADBEEF to addr=9'h010, funct3=010: MemWrite=1, a=9'h010, wd=32'hDEADBEEF in the grant cycle; no m1_rvalid.
REQ-024 m0 issues locked loads continuously while m1 requests, MAX_LOCK=8: m0 wins grants 1-8, m1 is granted on the 9th arbitration, then round-robin resumes.
REQ-025 m0 takes a locked grant and then drops req; m1 requests the next cycle: m1_gnt=1 immediately and the state returns to IDLE.
REQ-026 rd=32'h12345678 during an m0 load grant, and rst_n=0 in the next cycle: m0_rvalid stays 0, m0_rdata=0, and no gnt until rst_n=1.
